// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception initiator: prioritises the committing instruction's exception flags and
// any pending interrupt, strobes CP0, flushes the pipeline and hands a redirect PC to fetch.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_is_br,
  input  logic        commit_if_adel,
  input  logic        commit_ri,
  input  logic        commit_sys,
  input  logic        commit_bp,
  input  logic        commit_ov,
  input  logic        commit_mem_adel,
  input  logic        commit_mem_ades,
  input  logic [31:0] commit_vaddr,
  input  logic        commit_eret,
  output logic        commit_kill,
  input  logic        int_happen,
  input  logic [31:0] epc_in,
  output logic [6:0]  exc_type,
  output logic [31:0] exc_pc,
  output logic        exc_is_slot,
  output logic [31:0] exc_bad_vaddr,
  output logic        eret_o,
  output logic        flush_o,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // exc_type bit positions: {int, adel, ades, sys, bp, ri, ov}
  localparam logic [6:0] EXC_NONE = 7'b0000000;
  localparam logic [6:0] EXC_INT  = 7'b1000000;
  localparam logic [6:0] EXC_ADEL = 7'b0100000;
  localparam logic [6:0] EXC_ADES = 7'b0010000;
  localparam logic [6:0] EXC_SYS  = 7'b0001000;
  localparam logic [6:0] EXC_BP   = 7'b0000100;
  localparam logic [6:0] EXC_RI   = 7'b0000010;
  localparam logic [6:0] EXC_OV   = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              slot_r;
  logic [31:0]       redir_pc_r;
  logic              commit_ready_r;
  logic              flush_r;
  logic              redir_valid_r;

  logic              fire_s;
  logic [6:0]        cause_s;
  logic              trap_s;
  logic              eret_fire_s;

  // Highest-priority cause wins; instruction-fetch and load address errors share the adel bit.
  function automatic logic [6:0] pick_cause(
    input logic irq, input logic if_adel, input logic ri, input logic sys,
    input logic bp, input logic ov, input logic mem_adel, input logic mem_ades
  );
    logic [6:0] c;
    if (irq)           c = EXC_INT;
    else if (if_adel)  c = EXC_ADEL;
    else if (ri)       c = EXC_RI;
    else if (sys)      c = EXC_SYS;
    else if (bp)       c = EXC_BP;
    else if (ov)       c = EXC_OV;
    else if (mem_adel) c = EXC_ADEL;
    else if (mem_ades) c = EXC_ADES;
    else               c = EXC_NONE;
    return c;
  endfunction

  // Firing-cycle decode: cause selection, trap/eret qualification and CP0 strobes.
  always_comb begin
    fire_s        = 1'b0;
    cause_s       = EXC_NONE;
    trap_s        = 1'b0;
    eret_fire_s   = 1'b0;
    exc_type      = EXC_NONE;
    exc_pc        = 32'h0000_0000;
    exc_is_slot   = 1'b0;
    exc_bad_vaddr = 32'h0000_0000;
    commit_kill   = 1'b0;
    eret_o        = 1'b0;

    fire_s  = (state_r == IDLE) && commit_valid && !rst;
    cause_s = pick_cause(int_happen, commit_if_adel, commit_ri, commit_sys,
                         commit_bp, commit_ov, commit_mem_adel, commit_mem_ades);

    if (fire_s) begin
      trap_s      = (cause_s != EXC_NONE);
      eret_fire_s = commit_eret && (cause_s == EXC_NONE);
      exc_type    = cause_s;
      exc_pc      = commit_pc;
      exc_is_slot = slot_r;
      commit_kill = trap_s;
      eret_o      = eret_fire_s;
    end else begin
      trap_s      = 1'b0;
      eret_fire_s = 1'b0;
    end

    // Only an adel reached via the fetch flag reports the PC; everything else on adel/ades is data.
    if (trap_s && (cause_s == EXC_ADEL) && commit_if_adel) begin
      exc_bad_vaddr = commit_pc;
    end else if (trap_s && ((cause_s == EXC_ADEL) || (cause_s == EXC_ADES))) begin
      exc_bad_vaddr = commit_vaddr;
    end else begin
      exc_bad_vaddr = 32'h0000_0000;
    end
  end

  // Sequencer: IDLE -> FLUSH -> REDIRECT -> IDLE with registered handshake/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      flush_cnt_r    <= CNT_ZERO;
      slot_r         <= 1'b0;
      redir_pc_r     <= 32'h0000_0000;
      commit_ready_r <= 1'b1;
      flush_r        <= 1'b0;
      redir_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (trap_s || eret_fire_s) begin
            state_r        <= FLUSH;
            flush_cnt_r    <= CNT_LOAD;
            slot_r         <= 1'b0;
            redir_pc_r     <= trap_s ? EXC_VECTOR : epc_in;
            commit_ready_r <= 1'b0;
            flush_r        <= 1'b1;
          end else if (fire_s) begin
            slot_r <= commit_is_br;
          end else begin
            slot_r <= slot_r;
          end
        end
        FLUSH: begin
          slot_r <= 1'b0;
          if (flush_cnt_r == CNT_ZERO) begin
            state_r       <= REDIRECT;
            flush_r       <= 1'b0;
            redir_valid_r <= 1'b1;
          end else begin
            flush_cnt_r <= flush_cnt_r - CNT_ONE;
          end
        end
        REDIRECT: begin
          if (redir_ready) begin
            state_r        <= IDLE;
            redir_valid_r  <= 1'b0;
            commit_ready_r <= 1'b1;
          end else begin
            state_r <= REDIRECT;
          end
        end
        default: begin
          state_r        <= IDLE;
          flush_cnt_r    <= CNT_ZERO;
          slot_r         <= 1'b0;
          commit_ready_r <= 1'b1;
          flush_r        <= 1'b0;
          redir_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign commit_ready = commit_ready_r;
  assign flush_o      = flush_r;
  assign redir_valid  = redir_valid_r;
  assign redir_pc     = redir_pc_r;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed plus randomized bench for exc_commit_ctrl against a cycle-level behavioural model.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC   = 32'hBFC00380;
  localparam int          FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc;
  logic        commit_is_br, commit_if_adel, commit_ri, commit_sys, commit_bp, commit_ov;
  logic        commit_mem_adel, commit_mem_ades;
  logic [31:0] commit_vaddr;
  logic        commit_eret, commit_kill, int_happen;
  logic [31:0] epc_in;
  logic [6:0]  exc_type;
  logic [31:0] exc_pc, exc_bad_vaddr, redir_pc;
  logic        exc_is_slot, eret_o, flush_o, redir_valid, redir_ready;

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining flush cycles, pending redirect, slot flag, redirect target.
  int          m_flush_left;
  bit          m_redir_wait;
  bit          m_slot;
  logic [31:0] m_redir;

  exc_commit_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_is_br(commit_is_br), .commit_if_adel(commit_if_adel), .commit_ri(commit_ri),
    .commit_sys(commit_sys), .commit_bp(commit_bp), .commit_ov(commit_ov),
    .commit_mem_adel(commit_mem_adel), .commit_mem_ades(commit_mem_ades),
    .commit_vaddr(commit_vaddr), .commit_eret(commit_eret), .commit_kill(commit_kill),
    .int_happen(int_happen), .epc_in(epc_in), .exc_type(exc_type), .exc_pc(exc_pc),
    .exc_is_slot(exc_is_slot), .exc_bad_vaddr(exc_bad_vaddr), .eret_o(eret_o),
    .flush_o(flush_o), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    commit_valid = 0; commit_pc = 32'h0; commit_is_br = 0; commit_if_adel = 0; commit_ri = 0;
    commit_sys = 0; commit_bp = 0; commit_ov = 0; commit_mem_adel = 0; commit_mem_ades = 0;
    commit_vaddr = 32'h0; commit_eret = 0; int_happen = 0; epc_in = 32'h0; redir_ready = 0;
  endtask

  function automatic bit m_idle();
    return (m_flush_left == 0) && !m_redir_wait;
  endfunction

  function automatic bit m_fire();
    return m_idle() && commit_valid && !rst;
  endfunction

  // Expected cause from the architectural priority list.
  function automatic logic [6:0] m_cause();
    if (int_happen)      return 7'b1000000;
    if (commit_if_adel)  return 7'b0100000;
    if (commit_ri)       return 7'b0000010;
    if (commit_sys)      return 7'b0001000;
    if (commit_bp)       return 7'b0000100;
    if (commit_ov)       return 7'b0000001;
    if (commit_mem_adel) return 7'b0100000;
    if (commit_mem_ades) return 7'b0010000;
    return 7'b0000000;
  endfunction

  // Compare all outputs at the falling edge, with the inputs of this cycle applied.
  task automatic step_check();
    logic [6:0]  c;
    logic [31:0] bv;
    bit          f, trap;
    @(negedge clk);
    f    = m_fire();
    c    = f ? m_cause() : 7'b0;
    trap = (c != 7'b0);
    bv   = 32'h0;
    if (trap && !int_happen && commit_if_adel) bv = commit_pc;
    else if (trap && (c == 7'b0100000 || c == 7'b0010000)) bv = commit_vaddr;
    chk("commit_ready", {31'b0, commit_ready}, {31'b0, m_idle()});
    chk("flush_o", {31'b0, flush_o}, {31'b0, (m_flush_left > 0)});
    chk("redir_valid", {31'b0, redir_valid}, {31'b0, m_redir_wait});
    chk("redir_pc", redir_pc, m_redir);
    chk("exc_type", {25'b0, exc_type}, {25'b0, c});
    chk("exc_pc", exc_pc, f ? commit_pc : 32'h0);
    chk("exc_is_slot", {31'b0, exc_is_slot}, {31'b0, f && m_slot});
    chk("commit_kill", {31'b0, commit_kill}, {31'b0, trap});
    chk("eret_o", {31'b0, eret_o}, {31'b0, f && commit_eret && !trap});
    chk("bad_vaddr", exc_bad_vaddr, bv);
  endtask

  // Advance the model across the rising edge, then leave time for the next input update.
  task automatic step_clock();
    bit f, trap, er;
    f    = m_fire();
    trap = f && (m_cause() != 7'b0);
    er   = f && commit_eret && !trap;
    @(posedge clk);
    if (rst) begin
      m_flush_left = 0; m_redir_wait = 0; m_slot = 0; m_redir = 32'h0;
    end else if (trap || er) begin
      m_flush_left = FLUSH; m_slot = 0; m_redir = trap ? VEC : epc_in;
    end else if (f) begin
      m_slot = commit_is_br;
    end else if (m_flush_left > 0) begin
      m_slot = 0;
      m_flush_left--;
      if (m_flush_left == 0) m_redir_wait = 1;
    end else if (m_redir_wait && redir_ready) begin
      m_redir_wait = 0;
    end
    #1;
  endtask

  task automatic step();
    step_check();
    step_clock();
  endtask

  initial begin
    clear_in();
    rst = 1;
    m_flush_left = 0; m_redir_wait = 0; m_slot = 0; m_redir = 32'h0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();  // reset state

    // Interrupt overrides overflow.
    commit_valid = 1; int_happen = 1; commit_ov = 1; commit_pc = 32'h80001000;
    step_check();
    chk("int_type", {25'b0, exc_type}, 32'h40);
    chk("int_kill", {31'b0, commit_kill}, 32'h1);
    step_clock();
    clear_in(); redir_ready = 1;
    step(); step();
    step_check();
    chk("int_redir_pc", redir_pc, 32'hBFC00380);
    chk("int_redir_valid", {31'b0, redir_valid}, 32'h1);
    step_clock();

    // Delay-slot reserved instruction.
    clear_in(); commit_valid = 1; commit_is_br = 1; commit_pc = 32'h80000010;
    step();
    clear_in(); commit_valid = 1; commit_ri = 1; commit_pc = 32'h80000014;
    step_check();
    chk("slot_type", {25'b0, exc_type}, 32'h02);
    chk("slot_flag", {31'b0, exc_is_slot}, 32'h1);
    chk("slot_pc", exc_pc, 32'h80000014);
    step_clock();
    clear_in(); redir_ready = 1;
    repeat (4) step();

    // Load address error, then fetch adel + ri.
    clear_in(); commit_valid = 1; commit_mem_adel = 1; commit_vaddr = 32'h3; commit_pc = 32'h80000100;
    step_check();
    chk("ladel_type", {25'b0, exc_type}, 32'h20);
    chk("ladel_bv", exc_bad_vaddr, 32'h3);
    step_clock();
    clear_in(); redir_ready = 1; repeat (4) step();
    clear_in(); commit_valid = 1; commit_if_adel = 1; commit_ri = 1; commit_pc = 32'h80000201;
    step_check();
    chk("iadel_type", {25'b0, exc_type}, 32'h20);
    chk("iadel_bv", exc_bad_vaddr, 32'h80000201);
    step_clock();
    clear_in(); redir_ready = 1; repeat (4) step();

    // ERET with backpressure on the redirect.
    clear_in(); commit_valid = 1; commit_eret = 1; epc_in = 32'h80002000;
    step_check();
    chk("eret_strobe", {31'b0, eret_o}, 32'h1);
    chk("eret_kill", {31'b0, commit_kill}, 32'h0);
    step_clock();
    clear_in(); redir_ready = 0; commit_valid = 1;
    step(); step();
    repeat (5) begin
      step_check();
      chk("bp_pc", redir_pc, 32'h80002000);
      chk("bp_ready", {31'b0, commit_ready}, 32'h0);
      step_clock();
    end
    redir_ready = 1; commit_valid = 0;
    step(); step();

    // ERET overridden by syscall.
    clear_in(); commit_valid = 1; commit_eret = 1; commit_sys = 1; epc_in = 32'h80003000;
    step_check();
    chk("eretsys_eret", {31'b0, eret_o}, 32'h0);
    chk("eretsys_type", {25'b0, exc_type}, 32'h08);
    step_clock();

    // Reset during FLUSH aborts the redirect.
    clear_in(); step();
    rst = 1; step();
    rst = 0;
    step_check();
    chk("rstflush_ready", {31'b0, commit_ready}, 32'h1);
    chk("rstflush_flush", {31'b0, flush_o}, 32'h0);
    chk("rstflush_rv", {31'b0, redir_valid}, 32'h0);
    step_clock();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      commit_valid    = ($urandom_range(0, 9) < 7);
      commit_pc       = {$urandom_range(0, 32'hFFFF), 16'h0} | ($urandom & 32'hFFFC);
      commit_is_br    = ($urandom_range(0, 2) == 0);
      commit_if_adel  = ($urandom_range(0, 19) == 0);
      commit_ri       = ($urandom_range(0, 19) == 0);
      commit_sys      = ($urandom_range(0, 19) == 0);
      commit_bp       = ($urandom_range(0, 19) == 0);
      commit_ov       = ($urandom_range(0, 19) == 0);
      commit_mem_adel = ($urandom_range(0, 19) == 0);
      commit_mem_ades = ($urandom_range(0, 19) == 0);
      commit_vaddr    = $urandom;
      commit_eret     = ($urandom_range(0, 9) == 0);
      int_happen      = ($urandom_range(0, 24) == 0);
      epc_in          = $urandom;
      redir_ready     = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
